// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder for the CPU MEM stage.
// Accepts one word request at a time, waits LATENCY cycles, commits the
// access to a word array and emits a single-cycle response pulse.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 128,
  parameter int LATENCY     = 3
) (
  input  logic        clk_i,
  input  logic        rst_n,
  input  logic        req_valid_i,
  input  logic        req_write_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        req_ready_o,
  output logic        resp_valid_o,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o,
  output logic        busy_o
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  // The counter only ever holds values 0..LATENCY-1.
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
  // First byte address past the end of the array.
  localparam logic [31:0] ADDR_LIMIT = 32'(DEPTH_WORDS * 4);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } stateType;

  stateType         state;
  stateType         stateNext;
  logic [CNT_W-1:0] counter;
  logic [CNT_W-1:0] counterNext;
  logic             accept;
  logic             commit;

  logic             reqWriteLat;
  logic [31:0]      reqAddrLat;
  logic [31:0]      reqWdataLat;

  logic             accessErr;
  logic [IDX_W-1:0] wordIdx;

  logic [31:0]      respRdata;
  logic             respErr;

  // Storage starts cleared and is never touched by reset.
  logic [31:0]      mem [DEPTH_WORDS] = '{default: '0};

  // Error and index derive only from the latched address, never the live bus.
  assign accessErr = (reqAddrLat[1:0] != 2'b00) || (reqAddrLat >= ADDR_LIMIT);
  assign wordIdx   = reqAddrLat[IDX_W+1:2];

  // Next-state logic: accept in IDLE, count down in WAIT, single-cycle RESP.
  always_comb begin
    stateNext   = state;
    counterNext = counter;
    accept      = 1'b0;
    commit      = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid_i) begin
          accept      = 1'b1;
          counterNext = CNT_LOAD;
          stateNext   = WAIT;
        end
      end
      WAIT: begin
        if (counter == '0) begin
          commit    = 1'b1;
          stateNext = RESP;
        end else begin
          counterNext = counter - CNT_W'(1);
        end
      end
      RESP: begin
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // State and counter registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      state   <= IDLE;
      counter <= '0;
    end else begin
      state   <= stateNext;
      counter <= counterNext;
    end
  end

  // Capture the request fields at acceptance; a reset simply abandons them.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      reqWriteLat <= req_write_i;
      reqAddrLat  <= req_addr_i;
      reqWdataLat <= req_wdata_i;
    end
  end

  // Good stores land at the commit edge; reset on the same edge suppresses it.
  always_ff @(posedge clk_i) begin
    if (rst_n && commit && reqWriteLat && !accessErr) begin
      mem[wordIdx] <= reqWdataLat;
    end
  end

  // Response data/error are loaded at commit and cleared on every other edge.
  always_ff @(posedge clk_i) begin
    if (!rst_n || !commit) begin
      respRdata <= '0;
      respErr   <= 1'b0;
    end else begin
      respErr   <= accessErr;
      respRdata <= (!accessErr && !reqWriteLat) ? mem[wordIdx] : '0;
    end
  end

  assign req_ready_o  = (state == IDLE);
  assign busy_o       = (state != IDLE);
  assign resp_valid_o = (state == RESP);
  assign resp_rdata_o = respRdata;
  assign resp_err_o   = respErr;

endmodule
